// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cnn_pkg
//  Purpose : Shared definitions for the CNN feature-RAM writeback path:
//            bank count, writeback FSM state type, and the 2x2 bank map.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package cnn_pkg;

  localparam int NUM_BANKS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wb_state_t;

  // 2x2 interleave: even/odd row picks the upper bank bit, even/odd column
  // the lower, so any aligned 2x2 window touches each bank exactly once.
  function automatic logic [1:0] bank_2x2(input logic row_lsb, input logic col_lsb);
    return {row_lsb, col_lsb};
  endfunction

endpackage
`default_nettype wire

// File: rtl/feature_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module  : feature_addr_gen
//  Purpose : Position counters and bank/address generation for the feature
//            writeback. Conv mode walks column, row, channel; flat mode walks
//            a linear index round-robin across the banks.
//  Ports   : clk, reset       clock / synchronous active-high reset
//            clear            restart all counters at position 0
//            advance          move to the next position (beat accepted)
//            flat             1 = flat placement, 0 = 2x2 interleave
//            width/height     map geometry W, H (conv)
//            chan             channels C (conv) / element count N (flat)
//            base             per-bank base address
//            bank, addr       placement of the current position
//            last             current position is the final beat
//  Rev     : 1.0  initial release
// ============================================================================
module feature_addr_gen
  import cnn_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic              flat,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [DIM_W-1:0]  chan,
  input  logic [ADDR_W-1:0] base,
  output logic [1:0]        bank,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [DIM_W-1:0]  r_col;
  logic [DIM_W-1:0]  r_row;
  logic [DIM_W-1:0]  r_ch;
  logic [DIM_W-1:0]  r_idx;

  logic              w_col_end;
  logic              w_row_end;
  logic              w_ch_end;
  logic [ADDR_W-1:0] w_half_w;
  logic [ADDR_W-1:0] w_plane;
  logic [ADDR_W-1:0] w_conv_addr;
  logic [ADDR_W-1:0] w_flat_addr;

  assign w_col_end = (r_col == width  - DIM_W'(1));
  assign w_row_end = (r_row == height - DIM_W'(1));
  assign w_ch_end  = (r_ch  == chan   - DIM_W'(1));

  // Each bank holds a quarter of every channel plane: (W/2) x (H/2) words.
  assign w_half_w    = ADDR_W'(width >> 1);
  assign w_plane     = w_half_w * ADDR_W'(height >> 1);
  assign w_conv_addr = base + ADDR_W'(r_ch) * w_plane
                     + ADDR_W'(r_row >> 1) * w_half_w
                     + ADDR_W'(r_col >> 1);
  assign w_flat_addr = base + ADDR_W'(r_idx >> 2);

  assign bank = flat ? r_idx[1:0] : bank_2x2(r_row[0], r_col[0]);
  assign addr = flat ? w_flat_addr : w_conv_addr;
  assign last = flat ? (r_idx == chan - DIM_W'(1))
                     : (w_col_end && w_row_end && w_ch_end);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_col <= '0;
      r_row <= '0;
      r_ch  <= '0;
      r_idx <= '0;
    end else if (advance) begin
      r_idx <= r_idx + DIM_W'(1);
      if (w_col_end) begin
        r_col <= '0;
        if (w_row_end) begin
          r_row <= '0;
          r_ch  <= r_ch + DIM_W'(1);
        end else begin
          r_row <= r_row + DIM_W'(1);
        end
      end else begin
        r_col <= r_col + DIM_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/feature_writeback.sv
`default_nettype none
// ============================================================================
//  Module  : feature_writeback
//  Purpose : Accepts post-SSFR result bytes over valid/ready and writes them
//            into the 4-bank feature RAMs, 2x2-interleaved for conv layers
//            or round-robin for dense outputs. One registered write per beat.
//  Ports   : clk, reset        clock / synchronous active-high reset
//            start             pulse: latch cfg_* and begin a layer
//            cfg_flat          1 = flat placement, 0 = 2x2 interleave
//            cfg_width/height  output map W, H (conv)
//            cfg_chan          channels C (conv) / element count N (flat)
//            cfg_base          per-bank base address
//            res_valid/data    result stream in; res_ready out
//            wr_en/addr/data   one-hot bank write port (latency 1)
//            busy              layer in progress
//            layer_done        pulse coincident with the final write
//            cfg_err           sticky bad-config flag
//  Rev     : 1.0  initial release
// ============================================================================
module feature_writeback
  import cnn_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DIM_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cfg_flat,
  input  logic [DIM_W-1:0]     cfg_width,
  input  logic [DIM_W-1:0]     cfg_height,
  input  logic [DIM_W-1:0]     cfg_chan,
  input  logic [ADDR_W-1:0]    cfg_base,
  input  logic                 res_valid,
  input  logic [DATA_W-1:0]    res_data,
  output logic                 res_ready,
  output logic [NUM_BANKS-1:0] wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 busy,
  output logic                 layer_done,
  output logic                 cfg_err
);

  wb_state_t             r_state;
  wb_state_t             w_state_next;

  logic                  r_flat;
  logic [DIM_W-1:0]      r_width;
  logic [DIM_W-1:0]      r_height;
  logic [DIM_W-1:0]      r_chan;
  logic [ADDR_W-1:0]     r_base;

  logic                  w_start_idle;
  logic                  w_cfg_bad;
  logic                  w_accept;
  logic                  w_gen_last;
  logic [1:0]            w_gen_bank;
  logic [ADDR_W-1:0]     w_gen_addr;
  logic [NUM_BANKS-1:0]  w_onehot;

  // Starts arriving while a layer is in flight are simply ignored.
  assign w_start_idle = start && (r_state == IDLE);

  // Conv maps must split evenly into 2x2 windows; flat N=0 is a legal no-op.
  assign w_cfg_bad = !cfg_flat &&
                     ((cfg_width  == '0) || cfg_width[0]  ||
                      (cfg_height == '0) || cfg_height[0] ||
                      (cfg_chan   == '0));

  assign w_accept = res_valid && res_ready;
  assign w_onehot = NUM_BANKS'(1) << w_gen_bank;

  feature_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_start_idle),
    .advance (w_accept),
    .flat    (r_flat),
    .width   (r_width),
    .height  (r_height),
    .chan    (r_chan),
    .base    (r_base),
    .bank    (w_gen_bank),
    .addr    (w_gen_addr),
    .last    (w_gen_last)
  );

  always_comb begin
    w_state_next = r_state;
    res_ready    = 1'b0;
    busy         = 1'b0;
    layer_done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start_idle && !w_cfg_bad) begin
          w_state_next = (cfg_flat && (cfg_chan == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        res_ready = 1'b1;
        busy      = 1'b1;
        if (w_accept && w_gen_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        // The last beat's registered write lands in this cycle.
        busy         = 1'b1;
        layer_done   = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_flat   <= 1'b0;
      r_width  <= '0;
      r_height <= '0;
      r_chan   <= '0;
      r_base   <= '0;
      cfg_err  <= 1'b0;
      wr_en    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_idle) begin
        cfg_err <= w_cfg_bad;
        if (!w_cfg_bad) begin
          r_flat   <= cfg_flat;
          r_width  <= cfg_width;
          r_height <= cfg_height;
          r_chan   <= cfg_chan;
          r_base   <= cfg_base;
        end
      end
      wr_en <= w_accept ? w_onehot : '0;
      if (w_accept) begin
        wr_addr <= w_gen_addr;
        wr_data <= res_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_feature_writeback.sv
`default_nettype none
// ============================================================================
//  Module  : tb_feature_writeback
//  Purpose : Self-checking bench for feature_writeback. A placement model
//            derived from the layer geometry predicts every cycle's outputs;
//            directed layers add literal expectations on logged writes.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_feature_writeback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cfg_flat = 1'b0;
  logic [7:0]  cfg_width = '0;
  logic [7:0]  cfg_height = '0;
  logic [7:0]  cfg_chan = '0;
  logic [15:0] cfg_base = '0;
  logic        res_valid = 1'b0;
  logic [7:0]  res_data = '0;
  logic        res_ready;
  logic [3:0]  wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        layer_done;
  logic        cfg_err;

  always #5 clk = ~clk;

  feature_writeback #(.ADDR_W(16), .DATA_W(8), .DIM_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_flat   (cfg_flat),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_chan   (cfg_chan),
    .cfg_base   (cfg_base),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .layer_done (layer_done),
    .cfg_err    (cfg_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_run = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  bit          m_flat;
  int          m_w, m_h, m_c, m_base, m_total, m_k;
  logic [3:0]  e_en = '0;
  logic [15:0] e_addr = '0;
  logic [7:0]  e_data = '0;

  logic [3:0]  log_en[$];
  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];
  bit          log_done[$];

  // Where beat k of the current layer lands, from raster position alone.
  function automatic void target(input int k, output int bank, output int addr);
    int col, row, ch;
    if (m_flat) begin
      bank = k % 4;
      addr = (m_base + k / 4) % 65536;
    end else begin
      col  = k % m_w;
      row  = (k / m_w) % m_h;
      ch   = k / (m_w * m_h);
      bank = (row % 2) * 2 + (col % 2);
      addr = (m_base + ch * (m_w / 2) * (m_h / 2) + (row / 2) * (m_w / 2) + col / 2) % 65536;
    end
  endfunction

  function automatic void model_step();
    int bank, addr;
    e_en = '0;
    if (reset) begin
      m_run  = 1'b0;
      m_done = 1'b0;
      m_err  = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_run) begin
      if (res_valid) begin
        target(m_k, bank, addr);
        e_en   = 4'(1 << bank);
        e_addr = 16'(addr);
        e_data = res_data;
        m_k++;
        if (m_k == m_total) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (start) begin
      if (!cfg_flat && (cfg_width == 0 || cfg_width % 2 != 0 ||
                        cfg_height == 0 || cfg_height % 2 != 0 || cfg_chan == 0)) begin
        m_err = 1'b1;
      end else begin
        m_err   = 1'b0;
        m_flat  = cfg_flat;
        m_w     = cfg_width;
        m_h     = cfg_height;
        m_c     = cfg_chan;
        m_base  = cfg_base;
        m_total = cfg_flat ? m_c : m_w * m_h * m_c;
        m_k     = 0;
        if (m_total == 0) m_done = 1'b1;
        else              m_run  = 1'b1;
      end
    end
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("wr_en", {28'd0, wr_en}, {28'd0, e_en});
    if (e_en != 0) begin
      chk("wr_addr", {16'd0, wr_addr}, {16'd0, e_addr});
      chk("wr_data", {24'd0, wr_data}, {24'd0, e_data});
    end
    chk("layer_done", {31'd0, layer_done}, {31'd0, m_done});
    chk("busy", {31'd0, busy}, {31'd0, (m_run || m_done)});
    chk("res_ready", {31'd0, res_ready}, {31'd0, m_run});
    chk("cfg_err", {31'd0, cfg_err}, {31'd0, m_err});
    if (wr_en != 0) begin
      log_en.push_back(wr_en);
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_done.push_back(layer_done);
    end
    model_step();
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input bit f, input int w, input int h, input int c, input int b);
    cfg_flat   = f;
    cfg_width  = 8'(w);
    cfg_height = 8'(h);
    cfg_chan   = 8'(c);
    cfg_base   = 16'(b);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input int d);
    int n;
    n = 0;
    res_valid = 1'b1;
    res_data  = 8'(d);
    @(negedge clk);
    while (!res_ready) begin
      n++;
      if (n > 200) begin
        timeout_fail("handshake");
        res_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  // gap: 0 = back-to-back, 1 = one idle cycle between beats, 2 = random gaps
  task automatic send_beats(input int n, input int first, input int gap);
    for (int i = 0; i < n; i++) begin
      if (gap == 1 && i != 0) idle_cycles(1);
      if (gap == 2) idle_cycles($urandom_range(0, 2));
      send_beat(first + i);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy) begin
      n++;
      if (n > 100) begin
        timeout_fail("wait_idle");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b;
    idle_cycles(3);
    @(negedge clk);
    chk("rst_wr_en", {28'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {16'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, res_ready}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycles(2);

    // Conv 4x4x1 base 0, back-to-back
    b = log_en.size();
    do_start(1'b0, 4, 4, 1, 0);
    send_beats(16, 0, 0);
    wait_idle();
    chk("c1_count", 32'(log_en.size() - b), 32'd16);
    chk("c1_b5_en", {28'd0, log_en[b+5]}, 32'h8);
    chk("c1_b5_addr", {16'd0, log_addr[b+5]}, 32'h0);
    chk("c1_b10_en", {28'd0, log_en[b+10]}, 32'h1);
    chk("c1_b10_addr", {16'd0, log_addr[b+10]}, 32'h3);
    chk("c1_b15_en", {28'd0, log_en[b+15]}, 32'h8);
    chk("c1_b15_addr", {16'd0, log_addr[b+15]}, 32'h3);
    chk("c1_b15_data", {24'd0, log_data[b+15]}, 32'd15);
    chk("c1_b15_done", {31'd0, log_done[b+15]}, 32'd1);

    // Conv 4x4x2 base 0x100
    b = log_en.size();
    do_start(1'b0, 4, 4, 2, 16'h100);
    send_beats(32, 0, 0);
    wait_idle();
    chk("c2_count", 32'(log_en.size() - b), 32'd32);
    chk("c2_b16_en", {28'd0, log_en[b+16]}, 32'h1);
    chk("c2_b16_addr", {16'd0, log_addr[b+16]}, 32'h104);
    chk("c2_busy_after", {31'd0, busy}, 32'd0);

    // Flat N=10 base 0x20, valid every other cycle
    b = log_en.size();
    do_start(1'b1, 0, 0, 10, 16'h20);
    send_beats(10, 100, 1);
    wait_idle();
    chk("f1_count", 32'(log_en.size() - b), 32'd10);
    chk("f1_i9_en", {28'd0, log_en[b+9]}, 32'h2);
    chk("f1_i9_addr", {16'd0, log_addr[b+9]}, 32'h22);
    chk("f1_i9_data", {24'd0, log_data[b+9]}, 32'd109);

    // Flat N=0: done immediately, no writes
    b = log_en.size();
    do_start(1'b1, 0, 0, 0, 16'h10);
    @(negedge clk);
    chk("f0_done", {31'd0, layer_done}, 32'd1);
    wait_idle();
    chk("f0_count", 32'(log_en.size() - b), 32'd0);

    // Bad config W=3, then a good 2x2x1 layer clears the flag
    do_start(1'b0, 3, 4, 1, 0);
    @(negedge clk);
    chk("bad_err", {31'd0, cfg_err}, 32'd1);
    chk("bad_busy", {31'd0, busy}, 32'd0);
    chk("bad_ready", {31'd0, res_ready}, 32'd0);
    @(posedge clk);
    #1;
    b = log_en.size();
    do_start(1'b0, 2, 2, 1, 16'h50);
    @(negedge clk);
    chk("good_err_clr", {31'd0, cfg_err}, 32'd0);
    @(posedge clk);
    #1;
    send_beats(4, 0, 0);
    wait_idle();
    chk("good_count", 32'(log_en.size() - b), 32'd4);

    // Reset after 5 of 16 beats, then restart from base
    do_start(1'b0, 4, 4, 1, 16'h300);
    send_beats(5, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rr_wr_en", {28'd0, wr_en}, 32'd0);
    chk("rr_ready", {31'd0, res_ready}, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    b = log_en.size();
    do_start(1'b0, 4, 4, 1, 16'h300);
    send_beats(16, 50, 0);
    wait_idle();
    chk("rr_count", 32'(log_en.size() - b), 32'd16);
    chk("rr_first_en", {28'd0, log_en[b]}, 32'h1);
    chk("rr_first_addr", {16'd0, log_addr[b]}, 32'h300);

    // Start pulsed mid-layer with a different config is ignored
    b = log_en.size();
    do_start(1'b0, 4, 4, 1, 16'h40);
    send_beats(3, 0, 0);
    do_start(1'b0, 2, 2, 1, 16'h0);
    send_beats(13, 3, 0);
    wait_idle();
    chk("sr_count", 32'(log_en.size() - b), 32'd16);
    chk("sr_b3_en", {28'd0, log_en[b+3]}, 32'h2);
    chk("sr_b3_addr", {16'd0, log_addr[b+3]}, 32'h41);
    chk("sr_b15_addr", {16'd0, log_addr[b+15]}, 32'h43);

    // Randomized layers
    for (int r = 0; r < 24; r++) begin
      bit f, bad;
      int w, h, c, n, base;
      f    = ($urandom % 3) == 0;
      bad  = 1'b0;
      base = (($urandom % 4) == 0) ? 16'hFFF0 + int'($urandom % 16) : int'($urandom % 65536);
      if (f) begin
        w = $urandom % 256;
        h = $urandom % 256;
        c = $urandom_range(0, 30);
        n = c;
      end else begin
        w = 2 * $urandom_range(1, 4);
        h = 2 * $urandom_range(1, 3);
        c = $urandom_range(1, 3);
        case ($urandom % 8)
          0: begin w = w + 1; bad = 1'b1; end
          1: begin c = 0;     bad = 1'b1; end
          default: ;
        endcase
        n = w * h * c;
      end
      do_start(f, w, h, c, base);
      if (bad) begin
        idle_cycles(2);
      end else begin
        for (int i = 0; i < n; i++) begin
          idle_cycles($urandom_range(0, 2));
          if (i == n / 2 && ($urandom % 3) == 0) begin
            do_start(~f, 2, 2, 1, $urandom % 65536);
          end
          send_beat($urandom % 256);
        end
        wait_idle();
      end
    end

    idle_cycles(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
